// File: rtl/serial_adder_nand_pkg.sv
// Shared definitions for the bit-serial NAND adder.
//   sa_state_t : controller state encoding (IDLE=0, RUN=1, DONE=2)
//   SA_WIDTH   : default operand/result width
package serial_adder_nand_pkg;

    localparam int unsigned SA_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } sa_state_t;

endpackage

// File: rtl/full_adder_nand.sv
// One full-adder slice built from two NAND half adders and a NAND-form OR.
//   sum   : a ^ b ^ cin
//   carry : majority(a, b, cin)
//   a, b  : operand bits
//   cin   : carry-in bit
module full_adder_nand (
    output logic sum,
    output logic carry,
    input  logic a,
    input  logic b,
    input  logic cin
);

    logic s1;
    logic c1;
    logic c2;

    half_adder_nand u_ha0 (
        .sum   (s1),
        .carry (c1),
        .a     (a),
        .b     (b)
    );

    half_adder_nand u_ha1 (
        .sum   (sum),
        .carry (c2),
        .a     (s1),
        .b     (cin)
    );

    // c1 | c2 written as NAND(NAND(c1,c1), NAND(c2,c2))
    always_comb begin
        carry = ~(~(c1 & c1) & ~(c2 & c2));
    end

endmodule

// File: rtl/half_adder_nand.sv
// NAND-only half adder cell.
//   sum   : a ^ b
//   carry : a & b
//   a, b  : operand bits
module half_adder_nand (
    output logic sum,
    output logic carry,
    input  logic a,
    input  logic b
);

    logic n_ab;
    logic n_a;
    logic n_b;

    always_comb begin
        n_ab  = ~(a & b);
        n_a   = ~(a & n_ab);
        n_b   = ~(b & n_ab);
        sum   = ~(n_a & n_b);
        carry = ~(n_ab & n_ab);
    end

endmodule

// File: rtl/serial_adder_nand.sv
// Bit-serial ripple adder: one NAND full-adder slice reused over WIDTH cycles,
// with a carry flop closing the loop between cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, accepted only in IDLE (captures a, b, cin)
//   busy       : high while bits are processed
//   done       : one-cycle pulse when sum/cout are updated
//   sum, cout  : registered result of the last completed addition
module serial_adder_nand
    import serial_adder_nand_pkg::*;
#(
    parameter int unsigned WIDTH = SA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    sa_state_t        state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    // Only WIDTH-1 result bits need storing: the final bit goes straight to sum.
    logic [WIDTH-2:0] r_sh_q, r_sh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             s_bit;
    logic             c_out;
    logic [WIDTH-1:0] r_next;

    full_adder_nand u_fa (
        .sum   (s_bit),
        .carry (c_out),
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .cin   (carry_q)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_sh_d  = r_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        r_next  = {s_bit, r_sh_q};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                r_sh_d  = r_next[WIDTH-1:1];
                carry_d = c_out;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    sum_d   = r_next;
                    cout_d  = c_out;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_sh_q  <= r_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
        sum  = sum_q;
        cout = cout_q;
    end

endmodule
